btn_event_ctrl: RTL and testbench

- Turns debounced button levels into discrete events: SHORT press, LONG press, and optionally auto-REPEAT.
- Shares a single event output channel between all buttons. Uses a round-robin arbiter and a valid/ready handshake.
- Sits between the button debounce sampler and the mode/parameter control logic of the MIC-Xcorr top level.

---
 rtl/btn_evt_pkg.sv | 11 +
 rtl/btn_press_fsm.sv | 54 +++++
 rtl/btn_event_ctrl.sv | 93 +++++++++
 tb/tb_btn_event_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/btn_evt_pkg.sv
// btn_evt_pkg: event codes, per-button FSM states and id-width helper shared by btn_event_ctrl
package btn_evt_pkg;
  localparam logic [1:0] EVT_NONE   = 2'b00;
  localparam logic [1:0] EVT_SHORT  = 2'b01;
  localparam logic [1:0] EVT_LONG   = 2'b10;
  localparam logic [1:0] EVT_REPEAT = 2'b11;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PRESS = 2'd1, ST_LONG = 2'd2} btn_state_e;
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/btn_press_fsm.sv
// btn_press_fsm: per-button hold timer raising SHORT/LONG strobes; BTN_REPEAT_EN adds REPEAT while held
module btn_press_fsm
  import btn_evt_pkg::*;
#(
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       press_i,
  input  logic       tick_i,
  output logic       evt_o,
  output logic [1:0] code_o
);
  localparam int CW = $clog2((LONG_MS > REPEAT_MS ? LONG_MS : REPEAT_MS) + 1);
  btn_state_e    st_q;
  logic [CW-1:0] cnt_q;
  logic          hit_long;
  logic          cnt_max;
  assign cnt_max  = &cnt_q;
  assign hit_long = tick_i && cnt_q == CW'(LONG_MS - 1);
`ifdef BTN_REPEAT_EN
  logic hit_rep;
  assign hit_rep = tick_i && cnt_q == CW'(REPEAT_MS - 1);
  assign code_o  = st_q == ST_PRESS ? (!press_i ? EVT_SHORT : hit_long ? EVT_LONG : EVT_NONE)
                 : (st_q == ST_LONG && press_i && hit_rep) ? EVT_REPEAT : EVT_NONE;
`else
  assign code_o  = st_q != ST_PRESS ? EVT_NONE : !press_i ? EVT_SHORT : hit_long ? EVT_LONG : EVT_NONE;
`endif
  // strobe is combinational so the pending flag is set on the same edge as the state change
  assign evt_o = code_o != EVT_NONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q  <= ST_IDLE;
      cnt_q <= '0;
    end else
      case (st_q)
        ST_IDLE: if (press_i) begin
          st_q  <= ST_PRESS;
          cnt_q <= '0;
        end
        ST_PRESS: if (!press_i) st_q <= ST_IDLE;
          else if (hit_long) begin
            st_q  <= ST_LONG;
            cnt_q <= '0;
          end else if (tick_i && !cnt_max) cnt_q <= cnt_q + 1'b1;
        ST_LONG: if (!press_i) st_q <= ST_IDLE;
`ifdef BTN_REPEAT_EN
          else if (hit_rep) cnt_q <= '0;
          else if (tick_i && !cnt_max) cnt_q <= cnt_q + 1'b1;
`endif
        default: st_q <= ST_IDLE;
      endcase
endmodule

// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: button SHORT/LONG (+REPEAT under BTN_REPEAT_EN) events on one round-robin valid/ready channel
module btn_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int  BTN_WIDTH  = 4,
  parameter int  PRESCALE   = 50000,
  parameter int  LONG_MS    = 1000,
  parameter int  REPEAT_MS  = 200,
  parameter bit  ACTIVE_LOW = 1'b1,
  localparam int IDW        = idw(BTN_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BTN_WIDTH-1:0] Btn_Level,
  output logic                 Evt_Valid,
  input  logic                 Evt_Ready,
  output logic [IDW-1:0]       Evt_Id,
  output logic [1:0]           Evt_Code,
  output logic                 Evt_Ovf,
  input  logic                 Ovf_Clr
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [BTN_WIDTH-1:0]   btn_q, press, evt, pend_q, pend_d, rot;
  logic [2*BTN_WIDTH-1:0] dbl;
  logic [1:0]             code [BTN_WIDTH];
  logic [1:0]             pcode_q [BTN_WIDTH];
  logic [1:0]             pcode_d [BTN_WIDTH];
  logic [PW-1:0]          pre_q;
  logic [IDW-1:0]         rr_q, gnt_id, id_q;
  logic [1:0]             code_q;
  logic                   ms_tick, gnt_v, load, ovf_hit, vld_q, ovf_q;
  assign press     = ACTIVE_LOW ? ~btn_q : btn_q;
  assign ms_tick   = pre_q == PW'(PRESCALE - 1);
  assign load      = (!vld_q || Evt_Ready) && gnt_v;
  assign Evt_Valid = vld_q;
  assign Evt_Id    = id_q;
  assign Evt_Code  = code_q;
  assign Evt_Ovf   = ovf_q;
  for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_btn
    btn_press_fsm #(.LONG_MS(LONG_MS), .REPEAT_MS(REPEAT_MS)) u_fsm (
      .clk    (clk),
      .rst_n  (rst_n),
      .press_i(press[i]),
      .tick_i (ms_tick),
      .evt_o  (evt[i]),
      .code_o (code[i])
    );
  end
  // rotate pending so bit 0 is the RR pointer; lowest set bit is the grant
  assign dbl = {pend_q, pend_q} >> rr_q;
  assign rot = dbl[BTN_WIDTH-1:0];
  always_comb begin
    gnt_v  = |rot;
    gnt_id = '0;
    for (int k = BTN_WIDTH - 1; k >= 0; k--)
      if (rot[k]) gnt_id = IDW'((int'(rr_q) + k) % BTN_WIDTH);
  end
  always_comb begin
    pend_d  = pend_q;
    pcode_d = pcode_q;
    ovf_hit = 1'b0;
    for (int k = 0; k < BTN_WIDTH; k++)
      if (evt[k]) begin
        ovf_hit    = ovf_hit | (pend_q[k] & ~(load && gnt_id == IDW'(k)));
        pend_d[k]  = 1'b1;
        pcode_d[k] = code[k];
      end else if (load && gnt_id == IDW'(k)) pend_d[k] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      btn_q   <= ACTIVE_LOW ? '1 : '0;
      pre_q   <= '0;
      pend_q  <= '0;
      pcode_q <= '{default: EVT_NONE};
      rr_q    <= '0;
      vld_q   <= 1'b0;
      id_q    <= '0;
      code_q  <= EVT_NONE;
      ovf_q   <= 1'b0;
    end else begin
      btn_q   <= Btn_Level;
      pre_q   <= ms_tick ? '0 : pre_q + 1'b1;
      pend_q  <= pend_d;
      pcode_q <= pcode_d;
      ovf_q   <= ovf_hit | (ovf_q & ~Ovf_Clr);
      if (!vld_q || Evt_Ready) vld_q <= gnt_v;
      if (load) begin
        id_q   <= gnt_id;
        code_q <= pcode_q[gnt_id];
        rr_q   <= gnt_id == IDW'(BTN_WIDTH - 1) ? '0 : gnt_id + 1'b1;
      end
    end
endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb_btn_event_ctrl: scoreboard bench for btn_event_ctrl (default build; REPEAT events tallied under BTN_REPEAT_EN)
module tb_btn_event_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] Btn_Level = 4'hF;
  logic       Evt_Valid, Evt_Ready, Evt_Ovf, Ovf_Clr;
  logic [1:0] Evt_Id, Evt_Code;
  int         n_chk = 0, n_pass = 0, cyc = 0, xfer_cyc = 0, t0 = 0, n_rep = 0;
  int         exp_q[$];
  btn_event_ctrl #(
    .BTN_WIDTH(4), .PRESCALE(10), .LONG_MS(5), .REPEAT_MS(3), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Btn_Level(Btn_Level), .Evt_Valid(Evt_Valid),
    .Evt_Ready(Evt_Ready), .Evt_Id(Evt_Id), .Evt_Code(Evt_Code),
    .Evt_Ovf(Evt_Ovf), .Ovf_Clr(Ovf_Clr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input int id, input int code);
    exp_q.push_back(id * 4 + code);
  endtask
  task automatic press(input logic [3:0] m);
    Btn_Level = ~m;
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1);
    chk(tag, exp_q.size(), 0);
  endtask
  // scoreboard: every accepted event must match the oldest expectation
  always @(negedge clk)
    if (rst_n && Evt_Valid && Evt_Ready) begin
`ifdef BTN_REPEAT_EN
      if (Evt_Code == 2'b11) n_rep++;
      else
`endif
      if (exp_q.size() == 0) chk("extra_evt", {Evt_Id, Evt_Code}, 0);
      else begin
        chk("evt_id_code", {Evt_Id, Evt_Code}, exp_q.pop_front());
        xfer_cyc = cyc;
      end
    end
  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    Evt_Ready = 1'b1;
    Ovf_Clr   = 1'b0;
    #2 rst_n = 1'b0;
    step(3);
    chk("rst_vld", Evt_Valid, 0);
    chk("rst_id", Evt_Id, 0);
    chk("rst_code", Evt_Code, 0);
    chk("rst_ovf", Evt_Ovf, 0);
    rst_n = 1'b1;
    step(5);
    // simultaneous release of 0,1,3 with RR pointer at 0
    press(4'b1011);
    step(20);
    press(4'b0000);
    push(0, 1); push(1, 1); push(3, 1);
    step(3);
    chk("multi_id0", Evt_Id, 0);
    step(1);
    chk("multi_id1", Evt_Id, 1);
    step(1);
    chk("multi_id3", Evt_Id, 3);
    step(1);
    chk("multi_end", Evt_Valid, 0);
    drain("multi_drain");
    // short press of btn1
    press(4'b0010);
    step(25);
    press(4'b0000);
    t0 = cyc;
    push(1, 1);
    step(3);
    chk("short_vld", Evt_Valid, 1);
    step(1);
    chk("short_1cyc", Evt_Valid, 0);
    chk("short_lat", xfer_cyc - t0, 3);
    drain("short_drain");
    // long press of btn2
    press(4'b0100);
    t0 = cyc;
    push(2, 2);
    step(80);
    chk("long_lat_44_53", int'(xfer_cyc - t0 >= 44 && xfer_cyc - t0 <= 53), 1);
    press(4'b0000);
    step(10);
    chk("long_no_rel", exp_q.size(), 0);
    chk("long_idle", Evt_Valid, 0);
`ifdef BTN_REPEAT_EN
    chk("repeat_seen", int'(n_rep >= 1), 1);
`endif
    // overflow: output held, second SHORT pending, then LONG overwrites it
    Evt_Ready = 1'b0;
    press(4'b0001);
    step(15);
    press(4'b0000);
    push(0, 1);
    step(5);
    chk("hold_vld", Evt_Valid, 1);
    press(4'b0001);
    step(15);
    press(4'b0000);
    step(5);
    chk("ovf_none", Evt_Ovf, 0);
    press(4'b0001);
    push(0, 2);
    step(60);
    chk("ovf_set", Evt_Ovf, 1);
    chk("hold_id", Evt_Id, 0);
    chk("hold_code", Evt_Code, 1);
    press(4'b0000);
    step(3);
    Evt_Ready = 1'b1;
    step(1);
    chk("ovf_next_code", Evt_Code, 2);
    drain("ovf_drain");
    chk("ovf_sticky", Evt_Ovf, 1);
    Ovf_Clr = 1'b1;
    step(1);
    Ovf_Clr = 1'b0;
    chk("ovf_clr", Evt_Ovf, 0);
    // RR fairness: after Id 0 transfers, 2 is granted before 0
    Evt_Ready = 1'b0;
    press(4'b0001);
    step(15);
    press(4'b0000);
    push(0, 1);
    step(5);
    press(4'b0101);
    step(15);
    press(4'b0000);
    push(2, 1); push(0, 1);
    step(5);
    chk("rr_hold_id", Evt_Id, 0);
    Evt_Ready = 1'b1;
    step(1);
    chk("rr_next_2", Evt_Id, 2);
    step(1);
    chk("rr_then_0", Evt_Id, 0);
    drain("rr_drain");
    // async reset mid-handshake with btn1 held through it
    Evt_Ready = 1'b0;
    press(4'b1000);
    step(15);
    press(4'b0010);
    step(5);
    chk("pre_rst_vld", Evt_Valid, 1);
    chk("pre_rst_id", Evt_Id, 3);
    rst_n = 1'b0;
    #1;
    chk("arst_vld", Evt_Valid, 0);
    chk("arst_id", Evt_Id, 0);
    chk("arst_code", Evt_Code, 0);
    exp_q.delete();
    step(3);
    rst_n = 1'b1;
    Evt_Ready = 1'b1;
    step(10);
    press(4'b0000);
    t0 = cyc;
    push(1, 1);
    step(6);
    chk("post_rst_lat", xfer_cyc - t0, 3);
    drain("final_drain");
    step(5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
